// File: rtl/Dcache.sv
// Shared types for the L1 data-cache port arbiter: request record,
// arbiter states and the cache word/address widths.
package Dcache;

  localparam int DCACHE_ADDR_W = 30;
  localparam int DCACHE_DATA_W = 32;
  localparam int DCACHE_MASK_W = DCACHE_DATA_W / 8;

  typedef struct packed {
    logic [DCACHE_ADDR_W-1:0] addr;
    logic [DCACHE_DATA_W-1:0] data;
    logic [DCACHE_MASK_W-1:0] mask;
    logic                     we;
  } dcache_req_t;

  typedef enum logic {
    ST_ISSUE  = 1'b0,
    ST_REPLAY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/l1dcache_core_if.sv
// Single-port L1 data-cache core interface; the Client side issues one
// request per cycle and sees its data/hit exactly one cycle later.
interface l1dcache_core_if;

  logic                             en;
  logic                             enW;
  logic                             kill;
  logic [Dcache::DCACHE_ADDR_W-1:0] addr;
  logic [Dcache::DCACHE_DATA_W-1:0] reqData;
  logic [Dcache::DCACHE_MASK_W-1:0] mask;
  logic [Dcache::DCACHE_DATA_W-1:0] respData;
  logic                             hit;

  modport Client (output en, enW, kill, addr, reqData, mask, input respData, hit);
  modport Server (input en, enW, kill, addr, reqData, mask, output respData, hit);

endinterface

// File: rtl/dcache_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping around, as a one-hot grant plus its index.
module dcache_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  function automatic int wrap_idx(input int base, input int offs);
    return (base + offs) % N;
  endfunction

  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'(wrap_idx(int'(ptr_i), k));
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one L1 D-cache core port between NUM_REQ requesters.
// Optional miss replay is compiled in with `define DCACHE_ARB_MISS_RETRY_EN.
module dcache_port_arbiter
  import Dcache::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 15
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_REQ-1:0]                     reqValid,
  output logic [NUM_REQ-1:0]                     reqReady,
  input  logic [NUM_REQ-1:0][DCACHE_ADDR_W-1:0]  reqAddr,
  input  logic [NUM_REQ-1:0][DCACHE_DATA_W-1:0]  reqData,
  input  logic [NUM_REQ-1:0][DCACHE_MASK_W-1:0]  reqMask,
  input  logic [NUM_REQ-1:0]                     reqWe,
  output logic [NUM_REQ-1:0]                     respValid,
  output logic [DCACHE_DATA_W-1:0]               respData,
  output logic                                   respHit,
  l1dcache_core_if.Client                        cache
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             rsp_v_q, rsp_v_d;
  logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
  dcache_req_t      rep_q, rep_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               withhold, deliver, can_issue, gnt_fire, replay_fire;
  dcache_req_t        win_req;

  dcache_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i (reqValid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef DCACHE_ARB_MISS_RETRY_EN
  localparam int CNT_W = $clog2(MAX_RETRY + 1);
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

  // A miss is held back for replay until the limit, then handed over unresolved.
  assign withhold = rsp_v_q && !flush && !cache.hit && (retry_cnt_q != CNT_W'(MAX_RETRY));

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (flush || deliver) retry_cnt_d = '0;
    else if (withhold)    retry_cnt_d = retry_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_cnt_q <= '0;
    else     retry_cnt_q <= retry_cnt_d;
  end
`else
  assign withhold = 1'b0;
`endif

  // The cache slot after a withheld miss belongs to the replay, so no new grant then.
  assign deliver     = rsp_v_q && !flush && !withhold;
  assign can_issue   = !rst && !flush && (state_q == ST_ISSUE) && !withhold;
  assign gnt_fire    = can_issue && pick_any;
  assign replay_fire = (state_q == ST_REPLAY) && !flush;
  assign reqReady    = can_issue ? pick_grant : '0;

  assign win_req = '{addr: reqAddr[pick_idx], data: reqData[pick_idx],
                     mask: reqMask[pick_idx], we: reqWe[pick_idx]};

  always_comb begin
    cache.en      = 1'b0;
    cache.enW     = 1'b0;
    cache.addr    = '0;
    cache.reqData = '0;
    cache.mask    = '0;
    cache.kill    = flush;
    if (gnt_fire) begin
      cache.en      = 1'b1;
      cache.enW     = win_req.we;
      cache.addr    = win_req.addr;
      cache.reqData = win_req.data;
      cache.mask    = win_req.mask;
    end else if (replay_fire) begin
      cache.en      = 1'b1;
      cache.enW     = rep_q.we;
      cache.addr    = rep_q.addr;
      cache.reqData = rep_q.data;
      cache.mask    = rep_q.mask;
    end
  end

  always_comb begin
    respValid = '0;
    respData  = '0;
    respHit   = 1'b0;
    if (deliver) begin
      respValid[rsp_id_q] = 1'b1;
      respData            = cache.respData;
      respHit             = cache.hit;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_v_d  = 1'b0;
    rsp_id_d = rsp_id_q;
    rep_d    = rep_q;
    if (flush) begin
      state_d = ST_ISSUE;
    end else if (state_q == ST_REPLAY) begin
      state_d = ST_ISSUE;
      rsp_v_d = 1'b1;
    end else begin
      if (withhold) state_d = ST_REPLAY;
      if (gnt_fire) begin
        ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        rsp_v_d  = 1'b1;
        rsp_id_d = pick_idx;
        rep_d    = win_req;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ISSUE;
      ptr_q    <= '0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
      rep_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
      rep_q    <= rep_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them (owner, data, hit, cycle).
module tb_dcache_port_arbiter;

`ifdef DCACHE_ARB_MISS_RETRY_EN
  localparam int TB_MAX_RETRY = 2;
`else
  localparam int TB_MAX_RETRY = 15;
`endif

  typedef struct {
    int unsigned id;
    logic [29:0] addr;
    logic        we;
    logic        hit;
    int unsigned due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       reqValid, reqReady, reqWe, respValid;
  logic [1:0][29:0] reqAddr;
  logic [1:0][31:0] reqData;
  logic [1:0][3:0]  reqMask;
  logic [31:0]      respData;
  logic             respHit;

  l1dcache_core_if cif ();

  dcache_port_arbiter #(.NUM_REQ(2), .MAX_RETRY(TB_MAX_RETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqAddr   (reqAddr),
    .reqData   (reqData),
    .reqMask   (reqMask),
    .reqWe     (reqWe),
    .respValid (respValid),
    .respData  (respData),
    .respHit   (respHit),
    .cache     (cif)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic hit_plan[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] cache_data(input logic [29:0] a);
    if (a == 30'h100) return 32'hDEADBEEF;
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction

  // Cache model: registered one-cycle response, hit taken from hit_plan (default hit).
  initial begin
    logic        cap_en;
    logic [29:0] cap_addr;
    cif.respData = 32'h0;
    cif.hit      = 1'b0;
    forever begin
      @(negedge clk);
      cap_en   = cif.en && !cif.kill;
      cap_addr = cif.addr;
      @(posedge clk);
      #1;
      if (cap_en) begin
        cif.respData = cache_data(cap_addr);
        cif.hit      = (hit_plan.size() > 0) ? hit_plan.pop_front() : 1'b1;
      end else begin
        cif.respData = 32'h0;
        cif.hit      = 1'b0;
      end
    end
  end

  // Monitor: every delivered response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && respValid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(respValid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("resp_owner", 32'(respValid), 32'(1) << e.id);
        check("resp_hit", 32'(respHit), 32'(e.hit));
        check("resp_cycle", cyc, e.due);
        if (!e.we) check("resp_data", respData, cache_data(e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic we);
    reqValid[i] = 1'b1;
    reqAddr[i]  = a;
    reqData[i]  = d;
    reqMask[i]  = m;
    reqWe[i]    = we;
  endtask

  task automatic push_exp(input int unsigned id, input logic [29:0] a, input logic we,
                          input logic hit, input int unsigned due);
    exp_t e;
    e.id = id; e.addr = a; e.we = we; e.hit = hit; e.due = due;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    reqValid = '0; reqWe = '0; reqAddr = '0; reqData = '0; reqMask = '0;

    // Reset state, with requests already pending.
    repeat (2) @(posedge clk);
    #2;
    set_req(0, 30'h55, 32'h0, 4'hF, 1'b0);
    set_req(1, 30'h66, 32'h0, 4'hF, 1'b1);
    smp();
    check("rst_reqReady", 32'(reqReady), 32'h0);
    check("rst_respValid", 32'(respValid), 32'h0);
    check("rst_respData", respData, 32'h0);
    check("rst_respHit", 32'(respHit), 32'h0);
    check("rst_cache_en", 32'(cif.en), 32'h0);
    check("rst_cache_enW", 32'(cif.enW), 32'h0);
    check("rst_cache_kill", 32'(cif.kill), 32'h0);
    check("rst_cache_addr", 32'(cif.addr), 32'h0);
    step(); rst = 1'b0; reqValid = '0;
    step();

    // Single requester load, hit.
    step(); set_req(0, 30'h100, 32'h0, 4'hF, 1'b0);
    smp();
    check("single_ready", 32'(reqReady), 32'h1);
    check("single_en", 32'(cif.en), 32'h1);
    check("single_enW", 32'(cif.enW), 32'h0);
    check("single_addr", 32'(cif.addr), 32'h100);
    push_exp(0, 30'h100, 1'b0, 1'b1, cyc + 1);
    step(); reqValid = '0;
    smp();
    check("single_ready_off", 32'(reqReady), 32'h0);
    step(); smp();
    check("idle_respData", respData, 32'h0);
    check("idle_cache_addr", 32'(cif.addr), 32'h0);

    // Back-to-back stores from requester 1 (ptr=1, returns to 0).
    for (int k = 0; k < 3; k++) begin
      step(); set_req(1, 30'h20 + 30'(k), 32'h1111_0000 + 32'(k), 4'b0001 << k, 1'b1);
      smp();
      check("b2b_ready", 32'(reqReady), 32'h2);
      check("b2b_enW", 32'(cif.enW), 32'h1);
      check("b2b_wdata", cif.reqData, 32'h1111_0000 + 32'(k));
      check("b2b_mask", 32'(cif.mask), 32'(4'b0001 << k));
      push_exp(1, 30'h20 + 30'(k), 1'b1, 1'b1, cyc + 1);
    end
    step(); reqValid = '0;
    smp();
    check("b2b_ready_off", 32'(reqReady), 32'h0);

    // Contention from ptr=0: grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      step();
      set_req(0, 30'h200 + 30'(k), 32'h0, 4'hF, 1'b0);
      set_req(1, 30'h300 + 30'(k), 32'h0, 4'hF, 1'b0);
      smp();
      check("cont_ready", 32'(reqReady), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_addr", 32'(cif.addr), (k % 2 == 0) ? 32'h200 + 32'(k) : 32'h300 + 32'(k));
      push_exp(k % 2, (k % 2 == 0) ? 30'h200 + 30'(k) : 30'h300 + 30'(k), 1'b0, 1'b1, cyc + 1);
    end
    step(); reqValid = '0;
    smp();

`ifndef DCACHE_ARB_MISS_RETRY_EN
    // Miss delivered immediately, unresolved.
    step(); hit_plan.push_back(1'b0); set_req(0, 30'h40, 32'h0, 4'hF, 1'b0);
    smp();
    check("miss_ready", 32'(reqReady), 32'h1);
    push_exp(0, 30'h40, 1'b0, 1'b0, cyc + 1);
    step(); reqValid = '0;
    smp();
`else
    // Retry: miss, miss, hit. Replays 2 and 4 cycles after grant, delivery at 5.
    step(); hit_plan.push_back(1'b0); hit_plan.push_back(1'b0);
    set_req(0, 30'h400, 32'h0, 4'hF, 1'b0);
    smp();
    check("retry_grant", 32'(reqReady), 32'h1);
    push_exp(0, 30'h400, 1'b0, 1'b1, cyc + 5);
    step(); reqValid = '0; set_req(1, 30'h500, 32'h0, 4'hF, 1'b0);
    smp();
    check("retry_c1_ready", 32'(reqReady), 32'h0);
    check("retry_c1_en", 32'(cif.en), 32'h0);
    for (int k = 2; k <= 4; k++) begin
      step(); smp();
      check("retry_ready_blocked", 32'(reqReady), 32'h0);
      check("retry_replay_en", 32'(cif.en), (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 0) check("retry_replay_addr", 32'(cif.addr), 32'h400);
    end
    step(); smp();
    check("retry_after_ready", 32'(reqReady), 32'h2);
    push_exp(1, 30'h500, 1'b0, 1'b1, cyc + 1);
    step(); reqValid = '0;
    smp();

    // Retry limit: always miss, delivered unresolved after MAX_RETRY=2 replays.
    step(); hit_plan.push_back(1'b0); hit_plan.push_back(1'b0); hit_plan.push_back(1'b0);
    set_req(0, 30'h600, 32'h0, 4'hF, 1'b0);
    smp();
    check("limit_grant", 32'(reqReady), 32'h1);
    push_exp(0, 30'h600, 1'b0, 1'b0, cyc + 5);
    step(); reqValid = '0;
    repeat (4) step();
    // Counter must be cleared: one miss then hit is a normal single replay.
    step(); hit_plan.push_back(1'b0); set_req(0, 30'h700, 32'h0, 4'hF, 1'b0);
    smp();
    check("limit_next_grant", 32'(reqReady), 32'h1);
    push_exp(0, 30'h700, 1'b0, 1'b1, cyc + 3);
    step(); reqValid = '0;
    repeat (3) step();

    // Flush during REPLAY.
    step(); hit_plan.push_back(1'b0); set_req(0, 30'h800, 32'h0, 4'hF, 1'b0);
    smp();
    check("rflush_grant", 32'(reqReady), 32'h1);
    step(); reqValid = '0;
    smp();
    step(); flush = 1'b1; set_req(1, 30'h900, 32'h0, 4'hF, 1'b0);
    smp();
    check("rflush_kill", 32'(cif.kill), 32'h1);
    check("rflush_en", 32'(cif.en), 32'h0);
    check("rflush_ready", 32'(reqReady), 32'h0);
    check("rflush_respValid", 32'(respValid), 32'h0);
    step(); flush = 1'b0;
    smp();
    check("rflush_next_grant", 32'(reqReady), 32'h2);
    push_exp(1, 30'h900, 1'b0, 1'b1, cyc + 1);
    step(); reqValid = '0;
    smp();
    step();
`endif

    // Flush in the response cycle.
    step(); set_req(0, 30'hA00, 32'h0, 4'hF, 1'b0);
    smp();
    check("flush_grant", 32'(reqReady), 32'h1);
    step(); flush = 1'b1; reqValid = '0; set_req(1, 30'hB00, 32'h0, 4'hF, 1'b0);
    smp();
    check("flush_kill", 32'(cif.kill), 32'h1);
    check("flush_en", 32'(cif.en), 32'h0);
    check("flush_ready", 32'(reqReady), 32'h0);
    check("flush_respValid", 32'(respValid), 32'h0);
    step(); flush = 1'b0;
    smp();
    check("flush_next_grant", 32'(reqReady), 32'h2);
    push_exp(1, 30'hB00, 1'b0, 1'b1, cyc + 1);
    step(); reqValid = '0;
    smp();
    repeat (3) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single L1 data-cache core port between NUM_REQ requesters, such as the memory stage and a page-table walker or debug port. Grants one request per cycle in round-robin order, tracks the one-cycle cache response and routes it to its owner. With the retry feature compiled in, it replays missed requests until they hit or a retry limit is reached. Sits between the requesting stages and the `l1dcache_core_if` client side.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- MAX_RETRY, 15, replay limit per request (retry feature only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill all in-flight and replaying requests
- reqValid  in  NUM_REQ  request present
- reqReady  out  NUM_REQ  one-hot grant, request accepted this cycle
- reqAddr  in  NUM_REQ×30  word address
- reqData  in  NUM_REQ×32  store data
- reqMask  in  NUM_REQ×4  byte mask
- reqWe  in  NUM_REQ  1 = store
- respValid  out  NUM_REQ  one-hot, response for that requester
- respData  out  32  load data (shared bus)
- respHit  out  1  1 = hit; 0 = miss delivered unresolved
- cache  l1dcache_core_if.Client  en, enW, addr, reqData, mask, kill out; respData, hit in

## Operation
- State: IDLE/ISSUE (arbitrate) and REPLAY (REPLAY exists only with the retry feature).
- Arbitration, in ISSUE state with flush=0:
  - Search starts at round-robin pointer `ptr` and takes the first i with reqValid[i].
  - reqReady[i]=1 and cache.en=1, combinationally in the same cycle.
  - cache.enW=reqWe[i]; addr/reqData/mask pass through from the winner.
  - After a grant, ptr ← (i+1) mod NUM_REQ.
  - No grant leaves ptr unchanged.
- A grant loads the response-tracking register: rspV=1, rspId=i, and the full request copy into the replay register.
- Cycle after grant, rspV=1, no miss handling:
  - respValid[rspId]=1.
  - respData=cache.respData, respHit=cache.hit.
  - Stores also receive a response; it is an ack and respData is don't-care.
- Back-to-back grants are allowed: a new grant may occur in the same cycle a response is delivered.
- flush=1:
  - cache.kill=1 and no grant.
  - rspV and the REPLAY state clear on the next edge.
  - Any response due that cycle is suppressed (respValid=0).
- Unused outputs drive 0: cache.addr/reqData/mask = 0 when en=0, respData=0 when no respValid.

## Timing
- Reset values: reqReady=0, respValid=0, respData=0, respHit=0, cache.en/enW/kill=0, ptr=0, rspV=0, state ISSUE, retry count=0.
- Request to response latency: exactly 1 cycle on hit; 1 + 2·k cycles after k replays.
- Throughput: 1 request per cycle with no misses.
- reqReady depends combinationally on reqValid and flush; no requester's valid may depend on its ready.
- Reset asserted mid-replay: the request is dropped with no response.
- The requester re-issues after reset.

## Configuration
- `DCACHE_ARB_MISS_RETRY_EN` defined, when the response cycle sees cache.hit=0:
  - The response is withheld; state ← REPLAY; retry count +1.
  - Next cycle the stored request is re-driven on cache (en=1) and all reqReady=0.
  - State → ISSUE with rspV=1.
  - When the count reaches MAX_RETRY, the miss is delivered with respHit=0 and the count cleared.
  - Any delivery clears the count.
  - Counter width is $clog2(MAX_RETRY+1).
- Macro undefined: misses are delivered immediately with respHit=0; no REPLAY state and no counter.

## Structure
- Shared package `Dcache`:
  - dcache_req_t (addr[29:0], data[31:0], mask[3:0], we).
  - state enum.
  - DCACHE_ADDR_W=30, DCACHE_DATA_W=32.
- Sub-module `dcache_rr_pick`:
  - Purely combinational round-robin picker.
  - Inputs: valid vector, ptr. Outputs: one-hot grant, index, any.
- The arbiter owns ptr, the response tracking, replay and the FSM.

## Test plan
- Single requester: req0 load 0x100 with cache.hit=1, respData=0xDEADBEEF → reqReady[0] in cycle 0; respValid[0], respData=0xDEADBEEF, respHit=1 in cycle 1.
- Contention: both valid for 4 cycles, ptr=0 → grants 0,1,0,1; responses alternate owner one cycle later.
- Back-to-back: req1 three consecutive stores → three grants in three cycles, three acks in the following cycles.
- Retry (macro on): hit=0 twice then 1 → re-issue 2 and 4 cycles after the grant; single respValid at cycle 5 with respHit=1; no grants during REPLAY.
- Retry limit: MAX_RETRY=2, always miss → delivery with respHit=0 after 2 replays; next request then proceeds normally.
- Flush: flush in the response cycle, and again during REPLAY → cache.kill=1, no respValid, next cycle accepts a new grant.
